freq_meter: RTL and testbench

- Measures an externally generated slow clock, for example the divided CPU clock or any board-level square wave, from the fast system clock domain.
- Reports two results:
  - the number of rising edges counted in a fixed gate window (frequency);
  - the number of system clocks between consecutive rising edges (period).
- Flags an input that has stopped toggling.
- Feeds the status/debug display path.

---
 rtl/freq_meter.sv | 146 ++++++++++++++
 tb/tb_freq_meter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter and edge-to-edge period meter for a slow asynchronous input
// Counts rising edges of sig_in_i per gate window and clk cycles between edges, and flags a stopped input.
module freq_meter #(
  parameter int unsigned GATE_CYCLES    = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 200000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] freq_cnt_o,
  output logic             freq_valid_o,
  output logic [CNT_W-1:0] period_cnt_o,
  output logic             period_valid_o,
  output logic             stalled_o,
  output logic             busy_o
);

  localparam int unsigned      GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [63:0]      TO_LAST   = 64'(TIMEOUT_CYCLES) - 64'd1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [GW-1:0]    gate_ctr_q, gate_ctr_d;
  logic [CNT_W-1:0] edge_ctr_q, edge_ctr_d, edge_sum;
  logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
  logic             freq_valid_q, freq_valid_d;
  logic [CNT_W-1:0] period_acc_q, period_acc_d, acc_inc;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             period_valid_q, period_valid_d;
  logic             seen_q, seen_d;
  logic             stalled_q, stalled_d;

  // s1/s2 resolve metastability; s3 holds the previous synchronised level
  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      state_q        <= IDLE;
      gate_ctr_q     <= '0;
      edge_ctr_q     <= '0;
      freq_cnt_q     <= '0;
      freq_valid_q   <= 1'b0;
      period_acc_q   <= '0;
      period_cnt_q   <= '0;
      period_valid_q <= 1'b0;
      seen_q         <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      s1_q           <= sig_in_i;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      state_q        <= state_d;
      gate_ctr_q     <= gate_ctr_d;
      edge_ctr_q     <= edge_ctr_d;
      freq_cnt_q     <= freq_cnt_d;
      freq_valid_q   <= freq_valid_d;
      period_acc_q   <= period_acc_d;
      period_cnt_q   <= period_cnt_d;
      period_valid_q <= period_valid_d;
      seen_q         <= seen_d;
      stalled_q      <= stalled_d;
    end
  end

  // Gate window FSM; a rise on the closing cycle still belongs to the closing window
  always_comb begin
    state_d      = state_q;
    gate_ctr_d   = gate_ctr_q;
    edge_ctr_d   = edge_ctr_q;
    freq_cnt_d   = freq_cnt_q;
    freq_valid_d = 1'b0;
    edge_sum     = (rise && (edge_ctr_q != CNT_MAX)) ? edge_ctr_q + 1'b1 : edge_ctr_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d    = GATE;
          gate_ctr_d = '0;
          edge_ctr_d = '0;
        end
      end
      GATE: begin
        if (gate_ctr_q == GATE_LAST) begin
          freq_cnt_d   = edge_sum;
          freq_valid_d = 1'b1;
          gate_ctr_d   = '0;
          edge_ctr_d   = '0;
          if (!enable_i) begin
            state_d = IDLE;
          end
        end else if (!enable_i) begin
          state_d = IDLE;
        end else begin
          gate_ctr_d = gate_ctr_q + 1'b1;
          edge_ctr_d = edge_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Period accumulator; the edge that ends a stall only re-arms the measurement
  always_comb begin
    period_acc_d   = period_acc_q;
    period_cnt_d   = period_cnt_q;
    period_valid_d = 1'b0;
    seen_d         = seen_q;
    stalled_d      = stalled_q;
    acc_inc        = (period_acc_q == CNT_MAX) ? period_acc_q : period_acc_q + 1'b1;
    if (!enable_i) begin
      period_acc_d = '0;
      seen_d       = 1'b0;
      stalled_d    = 1'b0;
    end else if (rise) begin
      period_acc_d = '0;
      seen_d       = 1'b1;
      stalled_d    = 1'b0;
      if (seen_q && !stalled_q) begin
        period_cnt_d   = acc_inc;
        period_valid_d = 1'b1;
      end
    end else begin
      period_acc_d = acc_inc;
      if (64'(period_acc_q) == TO_LAST) begin
        stalled_d = 1'b1;
      end
    end
  end

  assign freq_cnt_o     = freq_cnt_q;
  assign freq_valid_o   = freq_valid_q;
  assign period_cnt_o   = period_cnt_q;
  assign period_valid_o = period_valid_q;
  assign stalled_o      = stalled_q;
  assign busy_o         = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized check of freq_meter against an edge-time reference model
// Main DUT is compared every cycle with the model; a narrow-counter DUT checks saturation.
module tb_freq_meter;

  localparam int GATE = 1000;
  localparam int TOUT = 3000;
  localparam int MAXV = 65535;

  logic        clk = 1'b0;
  logic        rst_n, enable, sig_in;
  logic [15:0] freq_cnt, period_cnt;
  logic        freq_valid, period_valid, stalled, busy;

  logic        en2, sig2;
  logic [3:0]  freq_cnt2, period_cnt2;
  logic        freq_valid2, period_valid2, stalled2, busy2;

  int total = 0;
  int bad   = 0;
  int n_fv2 = 0;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TOUT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in_i(sig_in), .enable_i(enable),
    .freq_cnt_o(freq_cnt), .freq_valid_o(freq_valid),
    .period_cnt_o(period_cnt), .period_valid_o(period_valid),
    .stalled_o(stalled), .busy_o(busy)
  );

  freq_meter #(.GATE_CYCLES(64), .TIMEOUT_CYCLES(TOUT), .CNT_W(4)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .sig_in_i(sig2), .enable_i(en2),
    .freq_cnt_o(freq_cnt2), .freq_valid_o(freq_valid2),
    .period_cnt_o(period_cnt2), .period_valid_o(period_valid2),
    .stalled_o(stalled2), .busy_o(busy2)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: edge indices and time differences ----------------
  bit hq[$];
  int n = 0;
  bit in_win = 0;
  int win_start = 0, win_cnt = 0;
  int ref_e = 0;
  bit seen_m = 0, st_m = 0;
  int ef = 0, ep = 0;
  bit efv = 0, epv = 0;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic void model_step(input bit r, input bit e, input bit s);
    int sz, rise, k, acc;
    n++;
    efv = 0;
    epv = 0;
    if (!r) begin
      hq.delete();
      in_win = 0; win_cnt = 0; ref_e = n; seen_m = 0; st_m = 0;
      ef = 0; ep = 0;
      return;
    end
    sz   = hq.size();
    rise = ((sz >= 2 && hq[sz-2]) && !(sz >= 3 && hq[sz-3])) ? 1 : 0;
    hq.push_back(s);
    if (hq.size() > 4) void'(hq.pop_front());
    if (!in_win) begin
      if (e) begin in_win = 1; win_start = n; win_cnt = 0; end
    end else begin
      k = n - win_start;
      if (k == GATE) begin
        ef  = sat(win_cnt + rise);
        efv = 1;
        if (e) begin win_start = n; win_cnt = 0; end
        else in_win = 0;
      end else if (!e) begin
        in_win = 0;
      end else begin
        win_cnt += rise;
      end
    end
    acc = sat(n - 1 - ref_e);
    if (!e) begin
      ref_e = n; seen_m = 0; st_m = 0;
    end else if (rise != 0) begin
      if (seen_m && !st_m) begin ep = sat(acc + 1); epv = 1; end
      ref_e = n; seen_m = 1; st_m = 0;
    end else if (acc == TOUT - 1) begin
      st_m = 1;
    end
  endfunction

  initial begin : compare
    bit r, e, s;
    logic [35:0] got, exp;
    forever begin
      @(posedge clk);
      r = rst_n; e = enable; s = sig_in;
      @(negedge clk);
      model_step(r, e, s);
      got = {freq_cnt, freq_valid, period_cnt, period_valid, stalled, busy};
      exp = {16'(ef), efv, 16'(ep), epv, st_m, in_win};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cycle %0d outputs: got f=%0d fv=%0b p=%0d pv=%0b st=%0b busy=%0b expected f=%0d fv=%0b p=%0d pv=%0b st=%0b busy=%0b",
                 n, freq_cnt, freq_valid, period_cnt, period_valid, stalled, busy,
                 ef, efv, ep, epv, st_m, in_win);
      end
    end
  end

  initial begin : narrow_monitor
    forever begin
      @(negedge clk);
      if (freq_valid2) begin
        n_fv2++;
        chk("sat_freq_cnt", int'(freq_cnt2), 15);
      end
      if (period_valid2) chk("narrow_period", int'(period_cnt2), 2);
    end
  end

  initial begin : narrow_sig
    sig2 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sig2 = ~sig2;
    end
  end

  // ---------------- stimulus ----------------
  bit wave_on = 0;
  int ph = 0, w_hi = 1, w_lo = 1;

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #2;
      if (wave_on) begin
        ph++;
        sig_in = ((ph % (w_hi + w_lo)) < w_hi);
      end
    end
  endtask

  task automatic start_wave(input int hi, input int lo);
    w_hi = hi; w_lo = lo; ph = 0; wave_on = 1; sig_in = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({freq_cnt, freq_valid, period_cnt, period_valid, stalled, busy}), 0);
  endtask

  initial begin : stim
    int fprev;
    rst_n = 1'b0; enable = 1'b0; sig_in = 1'b0; en2 = 1'b0;
    tick(4);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1; en2 = 1'b1;
    tick(3);

    // 50/50 square wave, first rise about 20 cycles after enable
    enable = 1'b1;
    tick(18);
    start_wave(50, 50);
    tick(3500);
    chk("square_freq", int'(freq_cnt), 10);
    chk("square_period", int'(period_cnt), 100);

    // input stops, then restarts
    wave_on = 0; sig_in = 1'b0;
    tick(3100);
    chk("stall_set", int'(stalled), 1);
    sig_in = 1'b1; tick(50); sig_in = 1'b0; tick(50);
    chk("stall_cleared", int'(stalled), 0);
    start_wave(50, 50);
    tick(150);
    chk("period_after_stall", int'(period_cnt), 100);

    // abort mid-window
    enable = 1'b0; wave_on = 0; sig_in = 1'b0;
    tick(5);
    start_wave(30, 30);
    enable = 1'b1;
    tick(501);
    enable = 1'b0;
    fprev = int'(freq_cnt);
    tick(1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_freq_hold", int'(freq_cnt), fprev);
    tick(3);
    enable = 1'b1;
    tick(1200);

    // single rise landing on the closing cycle of a window
    enable = 1'b0; wave_on = 0; sig_in = 1'b0;
    tick(5);
    enable = 1'b1;
    tick(998);
    sig_in = 1'b1;
    tick(2);
    sig_in = 1'b0;
    chk("edge_win_not_early", int'(freq_valid), 0);
    tick(1);
    chk("edge_win_valid", int'(freq_valid), 1);
    chk("edge_win_counted", int'(freq_cnt), 1);
    tick(1000);
    chk("next_win_valid", int'(freq_valid), 1);
    chk("next_win_empty", int'(freq_cnt), 0);

    // reset in the middle of a window
    start_wave(7, 9);
    tick(400);
    rst_n = 1'b0;
    tick(3);
    chk_all_zero("midwin_reset_outputs");
    rst_n = 1'b1;
    tick(1000);
    chk("post_reset_not_early", int'(freq_valid), 0);
    tick(1);
    chk("post_reset_first_valid", int'(freq_valid), 1);

    // randomized segments
    for (int seg = 0; seg < 10; seg++) begin
      case ($urandom_range(0, 3))
        0: begin
          enable = 1'b1;
          start_wave($urandom_range(1, 70), $urandom_range(1, 70));
          tick($urandom_range(300, 1500));
        end
        1: begin
          enable = 1'b1; wave_on = 0; sig_in = 1'b0;
          tick($urandom_range(2990, 3200));
        end
        2: begin
          enable = 1'b0;
          tick($urandom_range(1, 20));
          enable = 1'b1;
          start_wave($urandom_range(1, 40), $urandom_range(1, 40));
          tick($urandom_range(100, 900));
        end
        default: begin
          wave_on = 0;
          repeat ($urandom_range(3, 10)) begin
            sig_in = 1'b1; tick($urandom_range(1, 5));
            sig_in = 1'b0; tick($urandom_range(20, 300));
          end
        end
      endcase
    end

    chk("narrow_windows_seen", (n_fv2 > 0) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
